// File: rtl/demux_1cross16_tdm.sv
`default_nettype none
// ============================================================================
// Module   : demux_1cross16_tdm
// Function : 1-to-16 TDM demultiplexer, addressed or auto round-robin routing
// Revision : 1.0 - initial release
// ============================================================================
module demux_1cross16_tdm #(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      din,
  input  logic                  din_valid,
  input  logic                  mode,
  input  logic [3:0]            sel,
  input  logic                  frame_start,
  output logic [16*WIDTH-1:0]   dout,
  output logic [15:0]           dout_strobe,
  output logic                  frame_done,
  output logic [3:0]            ptr
);

  localparam logic [3:0] c_last_ch = 4'd15;

  logic [3:0]  w_target;
  logic [15:0] w_wr_en;
  logic [15:0] r_strobe;
  logic        r_frame_done;
  logic [3:0]  r_ptr;

  // frame_start only overrides the pointer in auto mode
  assign w_target = mode ? (frame_start ? 4'd0 : r_ptr) : sel;

  generate
    for (genvar k = 0; k < 16; k++) begin : g_chan
      logic [WIDTH-1:0] r_chan;

      assign w_wr_en[k] = din_valid && (w_target == 4'(k));

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_chan <= '0;
        end else if (w_wr_en[k]) begin
          r_chan <= din;
        end
      end

      assign dout[k*WIDTH +: WIDTH] = r_chan;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_strobe     <= '0;
      r_frame_done <= 1'b0;
      r_ptr        <= '0;
    end else begin
      r_strobe     <= w_wr_en;
      r_frame_done <= 1'b0;
      if (din_valid && mode) begin
        r_ptr        <= w_target + 4'd1;
        r_frame_done <= (w_target == c_last_ch);
      end else if (mode && frame_start) begin
        r_ptr <= '0;
      end
    end
  end

  assign dout_strobe = r_strobe;
  assign frame_done  = r_frame_done;
  assign ptr         = r_ptr;

endmodule
`default_nettype wire
